// File: rtl/fifo_pkg.sv
// Shared FIFO types and Gray/binary helpers for the write/read pointer controllers.
package fifo_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int PTRSIZE_DEF  = ADDRSIZE_DEF + 1;

    typedef logic [PTRSIZE_DEF-1:0]  ptr_t;
    typedef logic [ADDRSIZE_DEF-1:0] addr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return {1'b0, b[PTRSIZE_DEF-1:1]} ^ b;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = {PTRSIZE_DEF{1'b0}};
        for (int i = 0; i < PTRSIZE_DEF; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_lvl_if.sv
// Write-side bundle between the write client / read-pointer synchroniser and wptr_full_lvl.
interface wptr_full_lvl_if #(
    parameter int ADDRSIZE = fifo_pkg::ADDRSIZE_DEF
);
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   afull_thresh;
    logic                wovf_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                woverflow;

    modport master (
        output winc, wq2_rptr, afull_thresh, wovf_clr,
        input  waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  winc, wq2_rptr, afull_thresh, wovf_clr,
        output waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );
endinterface

// File: rtl/wptr_full_lvl_gray2bin_conv.sv
// Parametrised combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin_conv #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer controller: binary/Gray write pointer, full, almost-full,
// conservative fill level and sticky overflow, all registered from next-state values.
module wptr_full_lvl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter bit RESET_AF = 1'b0
) (
    input  logic           wclk,
    input  logic           wrst,
    wptr_full_lvl_if.slave wif
);

    localparam int              PW    = ADDRSIZE + 1;
    localparam logic [PW-1:0]   DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    logic [PW-1:0] wbin_r;
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] wlevel_r;
    logic          wfull_r;
    logic          walmost_full_r;
    logic          woverflow_r;

    logic          wpush_s;
    logic [PW-1:0] wbinnext_s;
    logic [PW-1:0] wgraynext_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] lvl_next_s;
    logic          full_next_s;
    logic          afull_next_s;
    logic          ovf_next_s;

    gray2bin_conv #(.W(PW)) u_rptr_conv (
        .gray (wif.wq2_rptr),
        .bin  (rbin_s)
    );

    // Next-state pointer, level and flag computation.
    always_comb begin
        wpush_s      = wif.winc & ~wfull_r;
        wbinnext_s   = wbin_r + {{ADDRSIZE{1'b0}}, wpush_s};
        wgraynext_s  = {1'b0, wbinnext_s[PW-1:1]} ^ wbinnext_s;
        // Lagging read pointer makes this an upper bound on true occupancy.
        lvl_next_s   = wbinnext_s - rbin_s;
        full_next_s  = (lvl_next_s == DEPTH);
        afull_next_s = (lvl_next_s >= wif.afull_thresh);
        if (wif.winc && wfull_r) begin
            ovf_next_s = 1'b1;
        end else if (wif.wovf_clr) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = woverflow_r;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_r         <= {PW{1'b0}};
            wptr_r         <= {PW{1'b0}};
            wlevel_r       <= {PW{1'b0}};
            wfull_r        <= 1'b0;
            walmost_full_r <= RESET_AF;
            woverflow_r    <= 1'b0;
        end else begin
            wbin_r         <= wbinnext_s;
            wptr_r         <= wgraynext_s;
            wlevel_r       <= lvl_next_s;
            wfull_r        <= full_next_s;
            walmost_full_r <= afull_next_s;
            woverflow_r    <= ovf_next_s;
        end
    end

    assign wif.waddr        = wbin_r[ADDRSIZE-1:0];
    assign wif.wptr         = wptr_r;
    assign wif.wlevel       = wlevel_r;
    assign wif.wfull        = wfull_r;
    assign wif.walmost_full = walmost_full_r;
    assign wif.woverflow    = woverflow_r;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Scoreboard bench for wptr_full_lvl (ADDRSIZE=4, RESET_AF=0) with directed vectors.
module tb_wptr_full_lvl;

    typedef struct {
        int         edge_no;
        logic [4:0] wptr;
        logic [3:0] waddr;
        logic [4:0] wlevel;
        logic       wfull;
        logic       waf;
        logic       wovf;
    } exp_t;

    logic wclk = 1'b0;
    logic wrst;
    exp_t q[$];
    int   edge_cnt = 0;
    int   n_vec    = 0;
    int   n_bad    = 0;

    wptr_full_lvl_if #(.ADDRSIZE(4)) wif ();

    wptr_full_lvl #(.ADDRSIZE(4), .RESET_AF(1'b0)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .wif  (wif)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) edge_cnt <= edge_cnt + 1;

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic cmp(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_cnt, act, exp_v);
        end
    endtask

    // Monitor: after each active edge, compare outputs against the queued expectation.
    always @(negedge wclk) begin : monitor
        exp_t e;
        if (q.size() > 0 && q[0].edge_no <= edge_cnt) begin
            e = q.pop_front();
            cmp("wptr",         int'(wif.wptr),         int'(e.wptr));
            cmp("waddr",        int'(wif.waddr),        int'(e.waddr));
            cmp("wlevel",       int'(wif.wlevel),       int'(e.wlevel));
            cmp("wfull",        int'(wif.wfull),        int'(e.wfull));
            cmp("walmost_full", int'(wif.walmost_full), int'(e.waf));
            cmp("woverflow",    int'(wif.woverflow),    int'(e.wovf));
        end
    end

    // Protocol check: synchronised read pointer must never imply more than DEPTH entries.
    always @(negedge wclk) begin
        if (!wrst) begin
            assert (wif.wlevel <= 5'd16)
                else $error("FAIL level_range: wlevel=%0d exceeds 16", wif.wlevel);
        end
    end

    task automatic step(input logic rst, input logic inc, input logic clr,
                        input logic [4:0] rptr, input logic [4:0] thr,
                        input logic [4:0] e_wptr, input logic [3:0] e_waddr,
                        input logic [4:0] e_lvl, input logic e_full,
                        input logic e_af, input logic e_ovf);
        exp_t e;
        wrst             = rst;
        wif.winc         = inc;
        wif.wovf_clr     = clr;
        wif.wq2_rptr     = rptr;
        wif.afull_thresh = thr;
        e.edge_no = edge_cnt + 1;
        e.wptr    = e_wptr;
        e.waddr   = e_waddr;
        e.wlevel  = e_lvl;
        e.wfull   = e_full;
        e.waf     = e_af;
        e.wovf    = e_ovf;
        q.push_back(e);
        @(posedge wclk);
        #1;
    endtask

    initial begin
        // Reset held two edges with winc=1: nothing increments.
        step(1'b1, 1'b1, 1'b0, 5'd0, 5'd12, 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5'd0, 5'd12, 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Fill to full, almost-full at 12, full at 16.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 5'd0, 5'd12, gray(i), 4'(i), 5'(i),
                 (i == 16), (i >= 12), 1'b0);
        end
        // 17th write rejected, overflow sets.
        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd12, 5'b11000, 4'd0, 5'd16, 1'b1, 1'b1, 1'b1);

        // Overflow set and clear together: set wins; then clear alone.
        step(1'b0, 1'b1, 1'b1, 5'd0, 5'd12, 5'b11000, 4'd0, 5'd16, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 5'd0, 5'd12, 5'b11000, 4'd0, 5'd16, 1'b1, 1'b1, 1'b0);

        // Drain view through the synchronised read pointer.
        step(1'b0, 1'b0, 1'b0, 5'b00110, 5'd12, 5'b11000, 4'd0, 5'd12, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'b00111, 5'd12, 5'b11000, 4'd0, 5'd11, 1'b0, 1'b0, 1'b0);

        // Advance to wbin=31 with reader at 16, then wrap with reader at 20.
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 1'b1, 1'b0, 5'b11000, 5'd12, gray(16 + k), 4'(k), 5'(k),
                 1'b0, (k >= 12), 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 5'b11110, 5'd12, 5'd0, 4'd0, 5'd12, 1'b0, 1'b1, 1'b0);

        // Mid-operation reset after 7 writes.
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd12, 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 5'd0, 5'd12, gray(i), 4'(i), 5'(i), 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 5'd0, 5'd12, 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd12, 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Threshold 0: almost-full even when empty.
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Threshold above DEPTH: almost-full never asserts, even when full.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 5'd0, 5'd17, gray(i), 4'(i), 5'(i),
                 (i == 16), 1'b0, 1'b0);
        end

        wif.winc = 1'b0;
        for (int t = 0; t < 10 && q.size() > 0; t++) begin
            @(negedge wclk);
        end
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
